// File: rtl/ft64_fcu_sched.sv
// Sequencer for the shared FT64 flow-control unit: oldest-first grant from head, operand load, EXEC/WAIT, result hold.
// Grant 1 cycle after req, result 3 cycles after req for non-WAIT ops; result held until done_rdy_i, no grants meanwhile.
module ft64_fcu_sched #(
  parameter int QENTRIES = 8,
  parameter int TAGW     = 3,
  parameter int WID      = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [QENTRIES-1:0] req_i,
  input  logic [TAGW-1:0]     head_i,
  input  logic                flush_i,
  input  logic                irq_i,
  input  logic                is_wait_i,
  input  logic [WID-1:0]      calc_bus_i,
  output logic [QENTRIES-1:0] gnt_o,
  output logic [TAGW-1:0]     sel_id_o,
  output logic                fcu_ld_o,
  output logic                busy_o,
  output logic                done_v_o,
  output logic [TAGW-1:0]     done_id_o,
  output logic [WID-1:0]      done_bus_o,
  output logic                done_irq_o,
  input  logic                done_rdy_i,
  output logic [15:0]         wait_cycles_o
);

  // S_LOAD is the operand-load cycle between the grant and EXEC.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_EXEC = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              state_q;
  logic [QENTRIES-1:0] gnt_q;
  logic [TAGW-1:0]     sel_id_q;
  logic                fcu_ld_q;
  logic                done_v_q;
  logic [TAGW-1:0]     done_id_q;
  logic [WID-1:0]      done_bus_q;
  logic                done_irq_q;
  logic [15:0]         wait_cnt_q;
  logic [15:0]         wait_cnt_d;

  logic                arb_found;
  logic [TAGW-1:0]     arb_idx;
  logic [TAGW-1:0]     scan_idx;
  logic [QENTRIES-1:0] gnt_onehot;

  // Rotating scan from head; the index wraps naturally in TAGW bits.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < QENTRIES; i++) begin
      scan_idx = head_i + TAGW'(i);
      if (!arb_found && req_i[scan_idx]) begin
        arb_found = 1'b1;
        arb_idx   = scan_idx;
      end
    end
  end

  assign gnt_onehot = {{(QENTRIES-1){1'b0}}, 1'b1} << arb_idx;
  assign wait_cnt_d = (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : wait_cnt_q + 16'd1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      sel_id_q   <= '0;
      fcu_ld_q   <= 1'b0;
      done_v_q   <= 1'b0;
      done_id_q  <= '0;
      done_bus_q <= '0;
      done_irq_q <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      gnt_q    <= '0;
      fcu_ld_q <= 1'b0;
      // Every cycle spent in WAIT counts, including the terminating and flushed ones.
      if (state_q == S_WAIT) begin
        wait_cnt_q <= wait_cnt_d;
      end
      if (flush_i) begin
        state_q  <= S_IDLE;
        done_v_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (arb_found) begin
              gnt_q    <= gnt_onehot;
              sel_id_q <= arb_idx;
              fcu_ld_q <= 1'b1;
              state_q  <= S_LOAD;
            end
          end
          S_LOAD: begin
            state_q <= S_EXEC;
          end
          S_EXEC: begin
            done_bus_q <= calc_bus_i;
            done_id_q  <= sel_id_q;
            if (is_wait_i && !calc_bus_i[0] && !irq_i) begin
              state_q <= S_WAIT;
            end else begin
              done_irq_q <= is_wait_i & irq_i & ~calc_bus_i[0];
              done_v_q   <= 1'b1;
              state_q    <= S_DONE;
            end
          end
          S_WAIT: begin
            // Expiry takes precedence over a same-cycle interrupt.
            if (calc_bus_i[0] || irq_i) begin
              done_bus_q <= calc_bus_i;
              done_irq_q <= ~calc_bus_i[0];
              done_v_q   <= 1'b1;
              state_q    <= S_DONE;
            end
          end
          S_DONE: begin
            if (done_rdy_i) begin
              done_v_q <= 1'b0;
              state_q  <= S_IDLE;
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign gnt_o         = gnt_q;
  assign sel_id_o      = sel_id_q;
  assign fcu_ld_o      = fcu_ld_q;
  assign busy_o        = (state_q != S_IDLE);
  assign done_v_o      = done_v_q;
  assign done_id_o     = done_id_q;
  assign done_bus_o    = done_bus_q;
  assign done_irq_o    = done_irq_q;
  assign wait_cycles_o = wait_cnt_q;

endmodule

// File: tb/tb_ft64_fcu_sched.sv
// Directed bench for ft64_fcu_sched: stimulus pushes expected results into a queue,
// a negedge monitor pops them on each accepted result handshake.
module tb_ft64_fcu_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  req;
  logic [2:0]  head;
  logic        flush;
  logic        irq;
  logic        is_wait;
  logic [63:0] calc;
  logic        done_rdy;
  logic [7:0]  gnt;
  logic [2:0]  sel_id;
  logic        fcu_ld;
  logic        busy;
  logic        done_v;
  logic [2:0]  done_id;
  logic [63:0] done_bus;
  logic        done_irq;
  logic [15:0] wait_cycles;

  typedef struct {
    logic [2:0]  id;
    logic [63:0] bus;
    logic        irq;
  } exp_t;

  exp_t sbq[$];
  int   total  = 0;
  int   bad    = 0;
  int   exp_wc = 0;

  always #5 clk = ~clk;

  ft64_fcu_sched #(.QENTRIES(8), .TAGW(3), .WID(64)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req),
    .head_i       (head),
    .flush_i      (flush),
    .irq_i        (irq),
    .is_wait_i    (is_wait),
    .calc_bus_i   (calc),
    .gnt_o        (gnt),
    .sel_id_o     (sel_id),
    .fcu_ld_o     (fcu_ld),
    .busy_o       (busy),
    .done_v_o     (done_v),
    .done_id_o    (done_id),
    .done_bus_o   (done_bus),
    .done_irq_o   (done_irq),
    .done_rdy_i   (done_rdy),
    .wait_cycles_o(wait_cycles)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] id, input logic [63:0] bus, input logic irqv);
    exp_t e;
    e.id  = id;
    e.bus = bus;
    e.irq = irqv;
    sbq.push_back(e);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt"},      64'(gnt),         64'h0);
    chk({tag, "_sel_id"},   64'(sel_id),      64'h0);
    chk({tag, "_fcu_ld"},   64'(fcu_ld),      64'h0);
    chk({tag, "_busy"},     64'(busy),        64'h0);
    chk({tag, "_done_v"},   64'(done_v),      64'h0);
    chk({tag, "_done_id"},  64'(done_id),     64'h0);
    chk({tag, "_done_bus"}, done_bus,         64'h0);
    chk({tag, "_done_irq"}, 64'(done_irq),    64'h0);
    chk({tag, "_wait_cyc"}, 64'(wait_cycles), 64'h0);
  endtask

  // Plain op, done_rdy high: gnt at +1, EXEC at +2, done_v at +3, idle at +4.
  task automatic op(input logic [7:0] r, input logic [2:0] h, input logic [2:0] eid, input logic [63:0] cb);
    logic [7:0] oh;
    oh = 8'h01 << eid;
    req = r; head = h; calc = cb; is_wait = 1'b0; irq = 1'b0; done_rdy = 1'b1;
    push(eid, cb, 1'b0);
    tick();
    chk("op_gnt",    64'(gnt),    64'(oh));
    chk("op_fcu_ld", 64'(fcu_ld), 64'h1);
    chk("op_sel_id", 64'(sel_id), 64'(eid));
    chk("op_busy",   64'(busy),   64'h1);
    req = 8'h00;
    tick();
    chk("op_gnt_pulse", 64'(gnt),    64'h0);
    chk("op_v_early",   64'(done_v), 64'h0);
    tick();
    chk("op_done_v", 64'(done_v), 64'h1);
    tick();
    chk("op_v_drop", 64'(done_v), 64'h0);
    chk("op_idle",   64'(busy),   64'h0);
  endtask

  // WAIT op: nwait<0 terminates in EXEC, otherwise nwait idle WAIT cycles precede the terminating one.
  task automatic wait_op(input logic [2:0] id, input int nwait, input logic [63:0] fcb,
                         input logic firq, input logic exp_irq);
    logic [7:0] oh;
    oh = 8'h01 << id;
    req = oh; head = 3'd0; is_wait = 1'b1; irq = 1'b0; calc = 64'h0; done_rdy = 1'b1;
    push(id, fcb, exp_irq);
    tick();
    chk("w_gnt", 64'(gnt), 64'(oh));
    req = 8'h00;
    if (nwait < 0) begin
      calc = fcb; irq = firq;
    end
    tick();
    if (nwait >= 0) begin
      for (int k = 0; k < nwait; k++) begin
        tick();
        chk("w_busy",   64'(busy),   64'h1);
        chk("w_v_idle", 64'(done_v), 64'h0);
      end
      tick();
      calc = fcb; irq = firq;
      exp_wc += nwait + 1;
    end
    tick();
    chk("w_done_v",   64'(done_v),      64'h1);
    chk("w_done_irq", 64'(done_irq),    64'(exp_irq));
    chk("w_wait_cyc", 64'(wait_cycles), 64'(exp_wc));
    irq = 1'b0; is_wait = 1'b0; calc = 64'h0;
    tick();
    chk("w_v_drop", 64'(done_v), 64'h0);
    chk("w_idle",   64'(busy),   64'h0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && flush === 1'b0 && done_v === 1'b1 && done_rdy === 1'b1) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got id %0d bus %0h want no result", done_id, done_bus);
        end else begin
          e = sbq.pop_front();
          chk("sb_done_id",  64'(done_id),  64'(e.id));
          chk("sb_done_bus", done_bus,      e.bus);
          chk("sb_done_irq", 64'(done_irq), 64'(e.irq));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = 8'h00; head = 3'd0; flush = 1'b0; irq = 1'b0;
    is_wait = 1'b0; calc = 64'h0; done_rdy = 1'b1;
    tick();
    tick();
    chk_reset_vals("rst0");
    rst = 1'b0;
    tick();

    // Single request, full latency profile.
    op(8'h20, 3'd0, 3'd5, 64'h1234);

    // Priority from head with wrap-around.
    op(8'b1000_0101, 3'd3, 3'd7, 64'h7007);
    op(8'b0000_0101, 3'd3, 3'd0, 64'h0A0A);
    op(8'b0000_0100, 3'd3, 3'd2, 64'h2222);

    // Back-to-back throughput: second grant 4 cycles after the first.
    req = 8'h03; head = 3'd0; calc = 64'h11; done_rdy = 1'b1;
    push(3'd0, 64'h11, 1'b0);
    tick();
    chk("tp_gnt0", 64'(gnt), 64'h01);
    req = 8'h02;
    tick();
    tick();
    chk("tp_done_v", 64'(done_v), 64'h1);
    calc = 64'h22;
    push(3'd1, 64'h22, 1'b0);
    tick();
    chk("tp_bubble_gnt", 64'(gnt),  64'h0);
    chk("tp_bubble_busy", 64'(busy), 64'h0);
    tick();
    chk("tp_gnt1",   64'(gnt),    64'h02);
    chk("tp_sel_id", 64'(sel_id), 64'h1);
    req = 8'h00;
    tick();
    tick();
    chk("tp_done_v1", 64'(done_v), 64'h1);
    tick();

    // WAIT: expiry, interrupt, simultaneous, and terminations in EXEC.
    wait_op(3'd3, 9, 64'hABCD_0001, 1'b0, 1'b0);
    wait_op(3'd4, 3, 64'h5550,      1'b1, 1'b1);
    wait_op(3'd6, 1, 64'h7771,      1'b1, 1'b0);
    wait_op(3'd1, -1, 64'h20,       1'b1, 1'b1);
    wait_op(3'd2, -1, 64'h31,       1'b0, 1'b0);

    // Backpressure: result held, pending request not granted.
    req = 8'h02; head = 3'd0; calc = 64'hBEEF; done_rdy = 1'b0;
    push(3'd1, 64'hBEEF, 1'b0);
    tick();
    chk("bp_gnt", 64'(gnt), 64'h02);
    req = 8'h40;
    push(3'd6, 64'h6666, 1'b0);
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_v",   64'(done_v),  64'h1);
      chk("bp_hold_bus", done_bus,     64'hBEEF);
      chk("bp_hold_id",  64'(done_id), 64'h1);
      chk("bp_no_gnt",   64'(gnt),     64'h0);
      tick();
    end
    done_rdy = 1'b1;
    tick();
    chk("bp_v_drop", 64'(done_v), 64'h0);
    chk("bp_bubble", 64'(gnt),    64'h0);
    tick();
    chk("bp_gnt2", 64'(gnt), 64'h40);
    calc = 64'h6666;
    req  = 8'h00;
    tick();
    tick();
    chk("bp_done_v2", 64'(done_v), 64'h1);
    tick();

    // Flush in EXEC.
    req = 8'h01; calc = 64'hDEAD;
    tick();
    req = 8'h00;
    tick();
    flush = 1'b1;
    tick();
    chk("fl_exec_busy", 64'(busy),   64'h0);
    chk("fl_exec_v",    64'(done_v), 64'h0);
    chk("fl_exec_gnt",  64'(gnt),    64'h0);
    flush = 1'b0;
    tick();

    // Flush in WAIT.
    req = 8'h02; is_wait = 1'b1; calc = 64'h0;
    tick();
    req = 8'h00;
    tick();
    tick();
    chk("fl_wait_in", 64'(busy), 64'h1);
    tick();
    flush = 1'b1;
    tick();
    chk("fl_wait_busy", 64'(busy),   64'h0);
    chk("fl_wait_v",    64'(done_v), 64'h0);
    flush = 1'b0; is_wait = 1'b0;
    tick();

    // Flush in DONE beats done_rdy; flush in IDLE blocks a grant.
    req = 8'h04; calc = 64'h99; done_rdy = 1'b1;
    tick();
    req = 8'h00;
    tick();
    tick();
    chk("fl_done_v_pre", 64'(done_v), 64'h1);
    flush = 1'b1;
    req   = 8'h08;
    tick();
    chk("fl_done_v",    64'(done_v), 64'h0);
    chk("fl_done_busy", 64'(busy),   64'h0);
    tick();
    chk("fl_idle_gnt", 64'(gnt), 64'h0);
    flush = 1'b0;
    calc  = 64'hAA;
    push(3'd3, 64'hAA, 1'b0);
    tick();
    chk("fl_after_gnt", 64'(gnt), 64'h08);
    req = 8'h00;
    tick();
    tick();
    chk("fl_after_v", 64'(done_v), 64'h1);
    tick();

    // Asynchronous reset during WAIT.
    req = 8'h20; is_wait = 1'b1; calc = 64'h0;
    tick();
    req = 8'h00;
    tick();
    tick();
    chk("rst_wait_busy", 64'(busy), 64'h1);
    rst = 1'b1;
    #2;
    chk_reset_vals("rst_async");
    tick();
    rst = 1'b0; is_wait = 1'b0;
    tick();
    chk_reset_vals("rst_after");

    tick();
    chk("sb_empty", 64'(sbq.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
